// File: rtl/led_pkg.sv
// Shared mode encodings for the LED pattern generator and related blocks.
package led_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_CHASE   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_COUNT   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd5;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock prescaler: one-cycle tick every CLK_HZ/TICK_HZ sysclk cycles.
// CLK_HZ/TICK_HZ must be at least 2 so the tick is a true single-cycle pulse.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 125000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..Div-1 and wrap.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  // Prescaler state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver with runtime-selectable patterns and programmable step period.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 125000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned N_LED     = 4,
  parameter int unsigned DUTY_BITS = 8,
  parameter int unsigned PERIOD_W  = 16
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic [N_LED-1:0]    led,
  output logic                tick
);

  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  stepcnt_q, stepcnt_d;
  logic [N_LED-1:0]     chase_q, chase_d;
  logic [N_LED-1:0]     count_q, count_d;
  logic                 blink_q, blink_d;
  logic [DUTY_BITS-1:0] duty_q, duty_d;
  logic                 dir_down_q, dir_down_d;
  logic [DUTY_BITS-1:0] pwm_q, pwm_d;
  logic [N_LED-1:0]     led_q, led_d;
  logic                 step;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // period_q is never 0, so period_q - 1 cannot underflow.
  assign step = tick && (stepcnt_q == period_q - 1'b1);

  // Next-state for configuration, step counter and pattern state; load wins over step.
  always_comb begin
    mode_d     = mode_q;
    period_d   = period_q;
    stepcnt_d  = stepcnt_q;
    chase_d    = chase_q;
    count_d    = count_q;
    blink_d    = blink_q;
    duty_d     = duty_q;
    dir_down_d = dir_down_q;
    pwm_d      = pwm_q + 1'b1;
    if (load) begin
      mode_d     = mode;
      period_d   = (period == '0) ? PERIOD_W'(1) : period;
      stepcnt_d  = '0;
      chase_d    = N_LED'(1);
      count_d    = '0;
      blink_d    = 1'b0;
      duty_d     = '0;
      dir_down_d = 1'b0;
    end else begin
      if (tick) begin
        stepcnt_d = step ? '0 : stepcnt_q + 1'b1;
      end
      if (step) begin
        case (mode_q)
          MODE_BLINK: blink_d = ~blink_q;
          MODE_CHASE: chase_d = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
          MODE_COUNT: count_d = count_q + 1'b1;
          MODE_BREATHE: begin
            // At either end the direction flips and duty holds for that step.
            if (!dir_down_q) begin
              if (duty_q == '1) dir_down_d = 1'b1;
              else              duty_d     = duty_q + 1'b1;
            end else begin
              if (duty_q == '0) dir_down_d = 1'b0;
              else              duty_d     = duty_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // LED drive decoded from current state; registered below.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_OFF:     led_d = '0;
      MODE_ON:      led_d = '1;
      MODE_BLINK:   led_d = {N_LED{blink_q}};
      MODE_CHASE:   led_d = chase_q;
      MODE_COUNT:   led_d = count_q;
      MODE_BREATHE: led_d = {N_LED{pwm_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      period_q   <= PERIOD_W'(1);
      stepcnt_q  <= '0;
      chase_q    <= N_LED'(1);
      count_q    <= '0;
      blink_q    <= 1'b0;
      duty_q     <= '0;
      dir_down_q <= 1'b0;
      pwm_q      <= '0;
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      period_q   <= period_d;
      stepcnt_q  <= stepcnt_d;
      chase_q    <= chase_d;
      count_q    <= count_d;
      blink_q    <= blink_d;
      duty_q     <= duty_d;
      dir_down_q <= dir_down_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: hand-written vector table, corner sequences
// and randomized load/mode/period traffic checked against a step-count model.
module tb_led_pattern_gen;

  logic        sysclk;
  logic        rst_n;
  logic [2:0]  mode;
  logic [15:0] period;
  logic        load;
  logic [3:0]  led;
  logic        tick;

  int checks = 0;
  int errors = 0;

  // Model: edges since reset release, ticks since last load, captured mode/period.
  int         m_e;
  int         m_ticks;
  int         m_per;
  logic [2:0] m_mode;

  typedef struct {
    bit          do_load;
    logic [2:0]  md;
    logic [15:0] pr;
    int          off;
    logic [3:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  led_pattern_gen #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .N_LED     (4),
    .DUTY_BITS (3),
    .PERIOD_W  (16)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .mode   (mode),
    .period (period),
    .load   (load),
    .led    (led),
    .tick   (tick)
  );

  initial sysclk = 1'b0;
  always #4 sysclk = ~sysclk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_e     = 0;
    m_ticks = 0;
    m_per   = 1;
    m_mode  = 3'd0;
  endfunction

  // Pattern as a function of completed step count k (and pwm phase for breathe).
  function automatic logic [3:0] exp_led(int md, int k, int pwm);
    int m;
    int duty;
    case (md)
      1: return 4'hF;
      2: return (k % 2 == 1) ? 4'hF : 4'h0;
      3: return 4'(1 << (k % 4));
      4: return 4'(k % 16);
      5: begin
        m    = k % 16;
        duty = (m < 8) ? m : 15 - m;
        return (pwm < duty) ? 4'hF : 4'h0;
      end
      default: return 4'h0;
    endcase
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic cycle(input logic ld, input logic [2:0] md, input logic [15:0] pr);
    int         pk;
    int         pm;
    int         ppwm;
    logic [3:0] el;
    @(negedge sysclk);
    load   = ld;
    mode   = md;
    period = pr;
    @(posedge sysclk);
    pm   = int'(m_mode);
    pk   = m_ticks / m_per;
    ppwm = m_e % 8;
    if (ld) begin
      m_mode  = md;
      m_per   = (pr == 16'd0) ? 1 : int'(pr);
      m_ticks = 0;
    end else if (m_e % 10 == 9) begin
      m_ticks++;
    end
    m_e++;
    el = exp_led(pm, pk, ppwm);
    #1;
    check("led", led, el);
    check("tick", tick, (m_e % 10 == 9));
  endtask

  // Run until tick is visible, so the next edge is a tick edge.
  task automatic sync_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cycle(1'b0, mode, period);
      n++;
    end
    check("sync_tick", tick, 1'b1);
  endtask

  initial begin
    int pos;
    int first_t;
    int second_t;
    int lit[6];
    int wstart[6] = '{32, 72, 82, 152, 162, 172};
    int wexp[6]   = '{3, 7, 7, 0, 0, 1};
    int n;

    rst_n  = 1'b0;
    load   = 1'b0;
    mode   = 3'd0;
    period = 16'd0;
    model_reset();
    #1;
    check("reset led", led, 4'h0);
    check("reset tick", tick, 1'b0);
    repeat (3) @(posedge sysclk);
    #2 rst_n = 1'b1;

    // Idle after reset: dark LEDs, tick on edges 9, 19, ...
    first_t  = -1;
    second_t = -1;
    for (int i = 1; i <= 25; i++) begin
      cycle(1'b0, 3'd0, 16'd0);
      if (tick === 1'b1) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
      if (i == 25) check("idle led", led, 4'h0);
    end
    check("first tick edge", first_t, 9);
    check("second tick edge", second_t, 19);

    // Vector table; loads are issued on a tick edge so offsets are exact.
    vecs.push_back('{1'b1, 3'd3, 16'd2, 1,   4'h1, "chase start"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 20,  4'h1, "chase hold"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 21,  4'h2, "chase step1"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 41,  4'h4, "chase step2"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 61,  4'h8, "chase step3"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 80,  4'h8, "chase msb hold"});
    vecs.push_back('{1'b0, 3'd3, 16'd2, 81,  4'h1, "chase wrap"});
    vecs.push_back('{1'b1, 3'd4, 16'd0, 1,   4'h0, "count start"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 10,  4'h0, "count hold"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 11,  4'h1, "count 1"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 21,  4'h2, "count 2"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 151, 4'hF, "count 15"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 160, 4'hF, "count 15 hold"});
    vecs.push_back('{1'b0, 3'd4, 16'd0, 161, 4'h0, "count wrap"});
    vecs.push_back('{1'b1, 3'd1, 16'd1, 1,   4'hF, "on"});
    vecs.push_back('{1'b1, 3'd0, 16'd1, 1,   4'h0, "off"});
    vecs.push_back('{1'b1, 3'd2, 16'd1, 11,  4'hF, "blink p1"});
    vecs.push_back('{1'b1, 3'd2, 16'd3, 1,   4'h0, "blink load on step"});
    vecs.push_back('{1'b0, 3'd2, 16'd3, 30,  4'h0, "blink before 3 ticks"});
    vecs.push_back('{1'b0, 3'd2, 16'd3, 31,  4'hF, "blink first toggle"});
    vecs.push_back('{1'b0, 3'd2, 16'd3, 61,  4'h0, "blink second toggle"});
    vecs.push_back('{1'b1, 3'd7, 16'd1, 21,  4'h0, "reserved mode"});

    pos = 0;
    foreach (vecs[i]) begin
      if (vecs[i].do_load) begin
        sync_tick();
        cycle(1'b1, vecs[i].md, vecs[i].pr);
        pos = 0;
      end
      while (pos < vecs[i].off) begin
        cycle(1'b0, vecs[i].md, vecs[i].pr);
        pos++;
      end
      check(vecs[i].name, led, vecs[i].exp);
    end

    // Breathe: lit cycles per 8-cycle PWM window equal the duty of that step.
    sync_tick();
    cycle(1'b1, 3'd5, 16'd1);
    foreach (lit[w]) lit[w] = 0;
    for (int p = 1; p <= 179; p++) begin
      cycle(1'b0, 3'd5, 16'd1);
      foreach (wstart[w]) begin
        if (p >= wstart[w] && p < wstart[w] + 8 && led[0] === 1'b1) lit[w]++;
      end
    end
    foreach (lit[w]) check("breathe lit count", lit[w], wexp[w]);

    // Randomized traffic; mode/period wiggle without load must be ignored.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 4)));
      end
      n = $urandom_range(1, 40);
      for (int c = 0; c < n; c++) begin
        cycle(1'b0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 4)));
      end
    end

    // Async reset mid-blink while lit.
    cycle(1'b1, 3'd2, 16'd1);
    n = 0;
    while (led !== 4'hF && n < 40) begin
      cycle(1'b0, 3'd2, 16'd1);
      n++;
    end
    check("blink lit before reset", led, 4'hF);
    #1;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    check("async reset led", led, 4'h0);
    check("async reset tick", tick, 1'b0);
    @(posedge sysclk);
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) cycle(1'b0, 3'd1, 16'd1);
    check("off after reset", led, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
